pipe_hazard_ctrl: RTL

- Pipeline control unit that drives the stall and flush inputs of the IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Inserts a one-cycle bubble on a load-use hazard and flushes wrong-path instructions on a taken branch resolved in EXE.
- Freezes the whole pipeline while a data-memory access waits for `dm_ready`; halts the core if that wait exceeds a timeout.
- Sits beside the pipeline registers: hazard inputs come from the ID and EXE stages, and the flush/stall outputs go back to the registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline definitions: register address bus width, the stall/flush
// enable levels and the hazard controller state encoding.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int RegAddrBus = 5;

    localparam logic StallEnable = 1'b1;
    localparam logic FlushEnable = 1'b1;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_HALT     = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline (ID/EXE/MEM stages and pipeline registers) and
// the hazard controller.
//   master : pipeline side, drives hazard sources, receives stall/flush/halt
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::RegAddrBus
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] exe_write_addr;
    logic                  exe_reg_write;
    logic                  exe_DM_read;
    logic                  exe_branch_taken;
    logic                  mem_req;
    logic                  dm_ready;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_exe_stall;
    logic                  exe_mem_stall;
    logic                  if_id_flush;
    logic                  id_exe_flush;
    logic                  halt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output exe_write_addr, exe_reg_write, exe_DM_read, exe_branch_taken,
        output mem_req, dm_ready,
        input  pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
        input  if_id_flush, id_exe_flush, halt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  exe_write_addr, exe_reg_write, exe_DM_read, exe_branch_taken,
        input  mem_req, dm_ready,
        output pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
        output if_id_flush, id_exe_flush, halt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Purely combinational load-use comparator; also reused by the forwarding unit.
//   id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used : ID-stage sources
//   exe_write_addr, exe_reg_write, exe_DM_read       : EXE-stage load info
//   lu                                               : load-use hazard
// -----------------------------------------------------------------------------
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = RegAddrBus
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] exe_write_addr,
    input  logic                  exe_reg_write,
    input  logic                  exe_DM_read,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1_addr == exe_write_addr);
    assign rs2_hit = id_rs2_used && (id_rs2_addr == exe_write_addr);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign lu = exe_DM_read && exe_reg_write && (|exe_write_addr)
              && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control: load-use bubble, taken-branch flush, memory-wait freeze
// with timeout halt. All stall/flush/halt outputs are combinational so the
// pipeline registers act on them at the same edge.
//   clk, rst        : clock, synchronous active-high reset
//   hz (slave)      : hazard sources in, stall/flush/halt out
//   perf_stall_cnt  : cycles with pc_stall (PIPE_HAZARD_PERF_EN only)
//   perf_flush_cnt  : cycles with if_id_flush (PIPE_HAZARD_PERF_EN only)
// Optional feature macro: PIPE_HAZARD_PERF_EN
//
// state       | meaning
// ------------+-------------------------------------------------------------
// HZ_RUN      | normal flow, bubble/flush decode active
// HZ_MEM_WAIT | data memory access outstanding, wait_cnt counts wait cycles
// HZ_HALT     | memory timeout, pipeline frozen until rst
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = RegAddrBus,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic             lu;
    logic             br;
    logic             freeze;

    logic pc_stall_c;
    logic if_id_stall_c;
    logic id_exe_stall_c;
    logic exe_mem_stall_c;
    logic if_id_flush_c;
    logic id_exe_flush_c;
    logic halt_c;

    hazard_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_cmp (
        .id_rs1_addr    (hz.id_rs1_addr),
        .id_rs2_addr    (hz.id_rs2_addr),
        .id_rs1_used    (hz.id_rs1_used),
        .id_rs2_used    (hz.id_rs2_used),
        .exe_write_addr (hz.exe_write_addr),
        .exe_reg_write  (hz.exe_reg_write),
        .exe_DM_read    (hz.exe_DM_read),
        .lu             (lu)
    );

    assign br     = hz.exe_branch_taken;
    assign freeze = hz.mem_req && !hz.dm_ready && (state != HZ_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (freeze) begin
                        state    <= HZ_MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                HZ_MEM_WAIT: begin
                    if (hz.dm_ready) begin
                        state    <= HZ_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        // wait_cnt holds at MEM_TIMEOUT from here on.
                        state <= HZ_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                HZ_HALT: begin
                    state <= HZ_HALT;
                end
                default: begin
                    state    <= HZ_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Priority: reset, halt, freeze, branch, load-use. A frozen pipeline
    // defers branch/load-use; they re-evaluate once the freeze lifts.
    always_comb begin
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        id_exe_stall_c  = 1'b0;
        exe_mem_stall_c = 1'b0;
        if_id_flush_c   = 1'b0;
        id_exe_flush_c  = 1'b0;
        halt_c          = 1'b0;
        if (rst) begin
            halt_c = 1'b0;
        end else if (state == HZ_HALT) begin
            pc_stall_c      = StallEnable;
            if_id_stall_c   = StallEnable;
            id_exe_stall_c  = StallEnable;
            exe_mem_stall_c = StallEnable;
            halt_c          = 1'b1;
        end else if (freeze) begin
            pc_stall_c      = StallEnable;
            if_id_stall_c   = StallEnable;
            id_exe_stall_c  = StallEnable;
            exe_mem_stall_c = StallEnable;
        end else if (br) begin
            // The ID instruction is discarded, which also resolves any load-use.
            if_id_flush_c  = FlushEnable;
            id_exe_flush_c = FlushEnable;
        end else if (lu) begin
            pc_stall_c     = StallEnable;
            if_id_stall_c  = StallEnable;
            id_exe_flush_c = FlushEnable;
        end
    end

    assign hz.pc_stall      = pc_stall_c;
    assign hz.if_id_stall   = if_id_stall_c;
    assign hz.id_exe_stall  = id_exe_stall_c;
    assign hz.exe_mem_stall = exe_mem_stall_c;
    assign hz.if_id_flush   = if_id_flush_c;
    assign hz.id_exe_flush  = id_exe_flush_c;
    assign hz.halt          = halt_c;

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall_c) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (if_id_flush_c) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
